// File: rtl/dht11_ascii_reporter.sv
`default_nettype none
// ============================================================================
//  Module      : dht11_ascii_reporter
//  Description : Captures a DHT11 measurement word on request, converts the
//                integer fields to decimal by repeated subtraction of 10, and
//                streams "H=hh.d% T=tt.dC<CR><LF>" one byte at a time over a
//                valid/ready handshake towards a UART transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
module dht11_ascii_reporter #(
  parameter bit EOL_CRLF        = 1'b1,  // 1: CR LF line end, 0: LF only
  parameter bit DASH_ON_INVALID = 1'b1   // 1: bad checksum prints '-' digits
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_data,
  input  logic        i_valid,
  input  logic        i_send,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        o_busy,
  output logic        o_done
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_S_IDLE   = 3'd0;
  localparam logic [2:0] c_S_CONV_H = 3'd1;
  localparam logic [2:0] c_S_CONV_T = 3'd2;
  localparam logic [2:0] c_S_SEND   = 3'd3;
  localparam logic [2:0] c_S_DONE   = 3'd4;

  // Index of the final LF byte; the CR is dropped in LF-only mode.
  localparam logic [4:0] c_LAST_IDX = EOL_CRLF ? 5'd16 : 5'd15;

  localparam logic [7:0] c_ASCII_0    = 8'h30;
  localparam logic [7:0] c_ASCII_DASH = 8'h2D;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [2:0] r_state;
  logic [4:0] r_idx;
  logic       r_valid_cap;
  logic [6:0] r_h_rem;    // humidity integer, becomes units digit after CONV_H
  logic [3:0] r_h_tens;
  logic [3:0] r_h_deci;
  logic [6:0] r_t_rem;    // temperature integer, becomes units digit after CONV_T
  logic [3:0] r_t_tens;
  logic [3:0] r_t_deci;
  logic [7:0] r_tx_data;
  logic       r_tx_valid;
  logic       r_busy;
  logic       r_done;

  // --------------------------------------------------------------------------
  // Capture-time clamping of the raw sensor fields
  // --------------------------------------------------------------------------
  logic [6:0] w_h_int_clamp;
  logic [3:0] w_h_deci_clamp;
  logic [6:0] w_t_int_clamp;
  logic [3:0] w_t_deci_clamp;

  assign w_h_int_clamp  = (i_data[31:24] > 8'd99) ? 7'd99 : i_data[30:24];
  assign w_h_deci_clamp = (i_data[23:16] > 8'd9)  ? 4'd9  : i_data[19:16];
  assign w_t_int_clamp  = (i_data[15:8]  > 8'd99) ? 7'd99 : i_data[14:8];
  assign w_t_deci_clamp = (i_data[7:0]   > 8'd9)  ? 4'd9  : i_data[3:0];

  // --------------------------------------------------------------------------
  // ASCII digit characters, replaced by '-' when the checksum was bad
  // --------------------------------------------------------------------------
  logic       w_dash;
  logic [7:0] w_ch_h_tens;
  logic [7:0] w_ch_h_unit;
  logic [7:0] w_ch_h_deci;
  logic [7:0] w_ch_t_tens;
  logic [7:0] w_ch_t_unit;
  logic [7:0] w_ch_t_deci;

  assign w_dash      = DASH_ON_INVALID && !r_valid_cap;
  assign w_ch_h_tens = w_dash ? c_ASCII_DASH : (c_ASCII_0 + {4'd0, r_h_tens});
  assign w_ch_h_unit = w_dash ? c_ASCII_DASH : (c_ASCII_0 + {1'b0, r_h_rem});
  assign w_ch_h_deci = w_dash ? c_ASCII_DASH : (c_ASCII_0 + {4'd0, r_h_deci});
  assign w_ch_t_tens = w_dash ? c_ASCII_DASH : (c_ASCII_0 + {4'd0, r_t_tens});
  assign w_ch_t_unit = w_dash ? c_ASCII_DASH : (c_ASCII_0 + {1'b0, r_t_rem});
  assign w_ch_t_deci = w_dash ? c_ASCII_DASH : (c_ASCII_0 + {4'd0, r_t_deci});

  // --------------------------------------------------------------------------
  // Byte that follows the one currently presented
  // --------------------------------------------------------------------------
  logic [4:0] w_next_idx;
  logic [7:0] w_next_byte;

  assign w_next_idx = r_idx + 5'd1;

  // Message ROM indexed by the upcoming byte position.
  always_comb begin
    w_next_byte = 8'h00;
    case (w_next_idx)
      5'd0:    w_next_byte = 8'h48;          // 'H'
      5'd1:    w_next_byte = 8'h3D;          // '='
      5'd2:    w_next_byte = w_ch_h_tens;
      5'd3:    w_next_byte = w_ch_h_unit;
      5'd4:    w_next_byte = 8'h2E;          // '.'
      5'd5:    w_next_byte = w_ch_h_deci;
      5'd6:    w_next_byte = 8'h25;          // '%'
      5'd7:    w_next_byte = 8'h20;          // ' '
      5'd8:    w_next_byte = 8'h54;          // 'T'
      5'd9:    w_next_byte = 8'h3D;          // '='
      5'd10:   w_next_byte = w_ch_t_tens;
      5'd11:   w_next_byte = w_ch_t_unit;
      5'd12:   w_next_byte = 8'h2E;          // '.'
      5'd13:   w_next_byte = w_ch_t_deci;
      5'd14:   w_next_byte = 8'h43;          // 'C'
      5'd15:   w_next_byte = EOL_CRLF ? 8'h0D : 8'h0A;
      5'd16:   w_next_byte = 8'h0A;
      default: w_next_byte = 8'h00;
    endcase
  end

  // Report sequencer: capture, two decimal conversions, then byte streaming.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_S_IDLE;
      r_idx       <= 5'd0;
      r_valid_cap <= 1'b0;
      r_h_rem     <= 7'd0;
      r_h_tens    <= 4'd0;
      r_h_deci    <= 4'd0;
      r_t_rem     <= 7'd0;
      r_t_tens    <= 4'd0;
      r_t_deci    <= 4'd0;
      r_tx_data   <= 8'h00;
      r_tx_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_S_IDLE: begin
          if (i_send) begin
            r_valid_cap <= i_valid;
            r_h_rem     <= w_h_int_clamp;
            r_h_deci    <= w_h_deci_clamp;
            r_t_rem     <= w_t_int_clamp;
            r_t_deci    <= w_t_deci_clamp;
            r_h_tens    <= 4'd0;
            r_t_tens    <= 4'd0;
            r_idx       <= 5'd0;
            r_busy      <= 1'b1;
            r_state     <= c_S_CONV_H;
          end
        end

        c_S_CONV_H: begin
          if (r_h_rem >= 7'd10) begin
            r_h_rem  <= r_h_rem - 7'd10;
            r_h_tens <= r_h_tens + 4'd1;
          end else begin
            r_state <= c_S_CONV_T;
          end
        end

        c_S_CONV_T: begin
          if (r_t_rem >= 7'd10) begin
            r_t_rem  <= r_t_rem - 7'd10;
            r_t_tens <= r_t_tens + 4'd1;
          end else begin
            // First byte is the constant 'H', so it can be loaded directly.
            r_idx      <= 5'd0;
            r_tx_data  <= 8'h48;
            r_tx_valid <= 1'b1;
            r_state    <= c_S_SEND;
          end
        end

        c_S_SEND: begin
          if (r_tx_valid && tx_ready) begin
            if (r_idx == c_LAST_IDX) begin
              r_tx_valid <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= c_S_DONE;
            end else begin
              r_idx     <= w_next_idx;
              r_tx_data <= w_next_byte;
            end
          end
        end

        c_S_DONE: begin
          r_idx   <= 5'd0;
          r_busy  <= 1'b0;
          r_state <= c_S_IDLE;
        end

        default: begin
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= c_S_IDLE;
        end
      endcase
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign o_busy   = r_busy;
  assign o_done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dht11_ascii_reporter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dht11_ascii_reporter
//  Description : Self-checking bench for dht11_ascii_reporter (CR LF and
//                LF-only instances), table vectors plus random reports.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dht11_ascii_reporter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_data = 32'd0;
  logic        i_valid = 1'b0;
  logic        i_send = 1'b0;
  logic        send_lf = 1'b0;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data, tx_data_lf;
  logic        tx_valid, tx_valid_lf;
  logic        o_busy, o_busy_lf;
  logic        o_done, o_done_lf;

  int tests = 0;
  int fails = 0;
  byte unsigned got_q[$];
  byte unsigned exp_q[$];

  typedef struct {
    logic [31:0] data;
    logic        valid;
    int          mode;     // 0: tx_ready held high, 1: random tx_ready
    bit          lf;       // run on the LF-only instance
    int          lat;
    string       msg;      // expected text without line ending
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  dht11_ascii_reporter #(.EOL_CRLF(1'b1), .DASH_ON_INVALID(1'b1)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .i_send(i_send),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .o_busy(o_busy), .o_done(o_done)
  );

  dht11_ascii_reporter #(.EOL_CRLF(1'b0), .DASH_ON_INVALID(1'b1)) dut_lf (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .i_send(send_lf),
    .tx_ready(tx_ready), .tx_data(tx_data_lf), .tx_valid(tx_valid_lf),
    .o_busy(o_busy_lf), .o_done(o_done_lf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Reference model: decimal text of the clamped fields.
  function automatic byte unsigned dig(input int n, input bit v);
    return v ? 8'(48 + n) : 8'h2D;
  endfunction

  task automatic model_expected(input logic [31:0] d, input logic v, input bit lf, output int lat);
    int hi, hd, ti, td;
    hi = (d[31:24] > 8'd99) ? 99 : int'(d[31:24]);
    hd = (d[23:16] > 8'd9)  ? 9  : int'(d[23:16]);
    ti = (d[15:8]  > 8'd99) ? 99 : int'(d[15:8]);
    td = (d[7:0]   > 8'd9)  ? 9  : int'(d[7:0]);
    exp_q.delete();
    exp_q.push_back("H"); exp_q.push_back("=");
    exp_q.push_back(dig(hi / 10, v)); exp_q.push_back(dig(hi % 10, v));
    exp_q.push_back("."); exp_q.push_back(dig(hd, v));
    exp_q.push_back("%"); exp_q.push_back(" ");
    exp_q.push_back("T"); exp_q.push_back("=");
    exp_q.push_back(dig(ti / 10, v)); exp_q.push_back(dig(ti % 10, v));
    exp_q.push_back("."); exp_q.push_back(dig(td, v));
    exp_q.push_back("C");
    if (!lf) exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    lat = hi / 10 + ti / 10 + 2;
  endtask

  task automatic expected_from_text(input string s, input bit lf);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    if (!lf) exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Issue one request and collect bytes until o_done.
  // inj: 0 none, 1 extra request while byte 5 pending, 2 extra request in o_done cycle.
  task automatic run_report(input logic [31:0] d, input logic v, input int mode,
                            input bit lf, input int inj, output int lat);
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    bit         seen_done = 1'b0;
    bit         injected = 1'b0;
    int         t = 0;
    logic       cv, cdone, cbusy;
    logic [7:0] cd;
    got_q.delete();
    lat = -1;
    @(negedge clk);
    i_data = d; i_valid = v;
    if (lf) send_lf = 1'b1; else i_send = 1'b1;
    @(negedge clk);
    i_send = 1'b0; send_lf = 1'b0;
    i_data = $urandom; i_valid = 1'($urandom_range(0, 1));
    cbusy = lf ? o_busy_lf : o_busy;
    chk("busy_after_send", {31'd0, cbusy}, 32'd1);
    while (!seen_done && t < 800) begin
      i_send = 1'b0; send_lf = 1'b0;
      cv    = lf ? tx_valid_lf : tx_valid;
      cd    = lf ? tx_data_lf  : tx_data;
      cdone = lf ? o_done_lf   : o_done;
      if (cv && lat < 0) lat = t;
      if (prev_stall) begin
        chk("stall_valid", {31'd0, cv}, 32'd1);
        chk("stall_data", {24'd0, cd}, {24'd0, prev_data});
      end
      if (cdone) begin
        seen_done = 1'b1;
        chk("done_valid_low", {31'd0, cv}, 32'd0);
        if (inj == 2) begin
          if (lf) send_lf = 1'b1; else i_send = 1'b1;
        end
      end
      tx_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inj == 1 && !injected && cv && got_q.size() == 5) begin
        if (lf) send_lf = 1'b1; else i_send = 1'b1;
        injected = 1'b1;
      end
      if (cv && tx_ready) got_q.push_back(cd);
      prev_stall = cv && !tx_ready;
      prev_data  = cd;
      if (!seen_done) begin
        @(negedge clk);
        t++;
      end
    end
    if (!seen_done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic verify(input string name, input int lat, input int exp_lat);
    int bad = -1;
    chk({name, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s_bytes: index %0d actual 0x%02h required 0x%02h",
               name, bad, got_q[bad], exp_q[bad]);
    end
    chk({name, "_latency"}, lat, exp_lat);
  endtask

  // After a message: the block must stay idle for n cycles.
  task automatic check_quiet(input string name, input int n);
    bit busy_seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      i_send = 1'b0; send_lf = 1'b0;
      if (o_busy || tx_valid || o_done) busy_seen = 1'b1;
    end
    chk(name, {31'd0, busy_seen}, 32'd0);
  endtask

  initial begin
    int lat, exp_lat, cnt, guard;
    bit done_seen;
    logic [31:0] d;
    logic v;
    int mode;
    bit lf;

    vecs[0] = '{32'h3700_1905, 1'b1, 0, 1'b0, 9,  "H=55.0% T=25.5C"};
    vecs[1] = '{32'h3700_1905, 1'b1, 1, 1'b0, 9,  "H=55.0% T=25.5C"};
    vecs[2] = '{32'h3700_1905, 1'b0, 0, 1'b0, 9,  "H=--.-% T=--.-C"};
    vecs[3] = '{32'h7B0C_6400, 1'b1, 1, 1'b0, 20, "H=99.9% T=99.0C"};
    vecs[4] = '{32'h0000_0000, 1'b1, 0, 1'b0, 2,  "H=00.0% T=00.0C"};
    vecs[5] = '{32'h0000_0000, 1'b1, 0, 1'b1, 2,  "H=00.0% T=00.0C"};
    vecs[6] = '{32'h0A00_0903, 1'b1, 1, 1'b1, 3,  "H=10.0% T=09.3C"};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_lf_idle", {29'd0, tx_valid_lf, o_busy_lf, o_done_lf}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors
    for (int k = 0; k < 7; k++) begin
      run_report(vecs[k].data, vecs[k].valid, vecs[k].mode, vecs[k].lf, 0, lat);
      expected_from_text(vecs[k].msg, vecs[k].lf);
      verify($sformatf("vec%0d", k), lat, vecs[k].lat);
    end
    check_quiet("idle_after_table", 3);

    // Extra requests during byte 5 and during the o_done cycle are dropped
    run_report(32'h3700_1905, 1'b1, 0, 1'b0, 1, lat);
    expected_from_text("H=55.0% T=25.5C", 1'b0);
    verify("ignore_mid", lat, 9);
    run_report(32'h3700_1905, 1'b1, 1, 1'b0, 2, lat);
    expected_from_text("H=55.0% T=25.5C", 1'b0);
    verify("ignore_done", lat, 9);
    check_quiet("no_second_msg", 6);

    // Request on the cycle right after o_done is accepted
    run_report(32'h1400_2801, 1'b1, 0, 1'b0, 0, lat);
    expected_from_text("H=20.0% T=40.1C", 1'b0);
    verify("b2b_first", lat, 8);
    run_report(32'h0509_4A07, 1'b1, 0, 1'b0, 0, lat);
    expected_from_text("H=05.9% T=74.7C", 1'b0);
    verify("b2b_second", lat, 9);
    check_quiet("idle_after_b2b", 3);

    // Reset while byte index 8 is pending
    @(negedge clk);
    i_data = 32'h3700_1905; i_valid = 1'b1; i_send = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    i_send = 1'b0;
    cnt = 0; guard = 0;
    while (!(tx_valid && cnt == 8) && guard < 200) begin
      if (tx_valid && tx_ready) cnt++;
      @(negedge clk);
      guard++;
    end
    chk("rst_mid_reach_idx8", {31'd0, (guard < 200)}, 32'd1);
    tx_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, o_busy}, 32'd0);
    rst = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_done || tx_valid) done_seen = 1'b1;
      @(negedge clk);
    end
    chk("rst_mid_no_done", {31'd0, done_seen}, 32'd0);
    run_report(32'h3700_1905, 1'b1, 1, 1'b0, 0, lat);
    expected_from_text("H=55.0% T=25.5C", 1'b0);
    verify("after_rst", lat, 9);

    // Random reports against the reference model
    for (int k = 0; k < 12; k++) begin
      d    = $urandom;
      if ($urandom_range(0, 1) == 0) d[31:24] = 8'($urandom_range(0, 99));
      if ($urandom_range(0, 1) == 0) d[15:8]  = 8'($urandom_range(0, 99));
      v    = ($urandom_range(0, 3) != 0);
      mode = int'($urandom_range(0, 1));
      lf   = 1'($urandom_range(0, 1));
      run_report(d, v, mode, lf, 0, lat);
      model_expected(d, v, lf, exp_lat);
      verify($sformatf("rand%0d_%08h", k, d), lat, exp_lat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dht11_ascii_reporter.md
Name: dht11_ascii_reporter

Overview:
- Downstream consumer of the DHT11 controller's 32-bit measurement word {humid_int, humid_deci, temp_int, temp_deci} and its checksum-OK level.
- On a send request, captures the word and converts the integer fields to decimal with a sequential repeated-subtract-10 converter.
- Streams a fixed ASCII report, e.g. "H=55.0% T=25.5C\r\n", one byte at a time to the UART transmitter over a valid/ready handshake.
- Sits between dht11_top and the UART TX path; the same send trigger may also drive the controller's start.

Parameters:
EOL_CRLF, 1, 1: line ends in CR LF (17-byte message); 0: LF only (16 bytes).
DASH_ON_INVALID, 1, 1: if the checksum flag is 0 at capture, all six digit positions are sent as '-' (0x2D); 0: digits are sent as-is.

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous active-high reset
i_data  in  32  [31:24] humid_int, [23:16] humid_deci, [15:8] temp_int, [7:0] temp_deci
i_valid  in  1  checksum-OK level from the controller, sampled at capture
i_send  in  1  single-cycle report request
tx_ready  in  1  UART TX can accept a byte
tx_data  out  8  ASCII byte
tx_valid  out  1  tx_data valid
o_busy  out  1  high in any state other than IDLE
o_done  out  1  one-cycle pulse after the last byte is accepted

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on the clk rising edge and overrides all other inputs.
- Reset values: tx_data=0x00, tx_valid=0, o_busy=0, o_done=0, state=IDLE, byte index=0, all capture and BCD registers 0.
- States: IDLE, CONV_H, CONV_T, SEND, DONE.
- IDLE:
  - On an edge where i_send=1, capture i_data and i_valid and go to CONV_H.
  - Each integer field >99 is clamped to 99 at capture.
  - Each deci field >9 is clamped to 9.
- CONV_H: each cycle, if the remainder is >=10, subtract 10 and increment the tens digit; otherwise move to CONV_T. Duration is tens_h+1 cycles.
- CONV_T: same rule on temp_int, then move to SEND. Duration is tens_t+1 cycles.
- Latency: tx_valid first rises tens_h+tens_t+2 clocks after the edge that sampled i_send.
- Message byte order (index 0..16): 'H','=',Ht,Hu,'.',Hd,'%',' ','T','=',Tt,Tu,'.',Td,'C',0x0D,0x0A.
  - Digits are encoded as 0x30+value.
  - With EOL_CRLF=0, 0x0D is omitted and the last index is 15.
- SEND handshake:
  - tx_valid=1 and tx_data is held stable until a cycle where tx_valid&&tx_ready.
  - On a transfer the index increments; the next byte is presented in the following cycle with tx_valid staying 1 (back-to-back allowed).
  - tx_ready may toggle arbitrarily; tx_data never changes while tx_valid=1 and tx_ready=0.
- End of message: a transfer of the last byte moves the state to DONE with tx_valid=0. DONE asserts o_done for exactly one cycle, then returns to IDLE.
- o_busy: low only in IDLE.
- i_send while busy (including the DONE cycle) is ignored and not queued. i_send on the cycle after o_done is accepted.
- Invalid data: with i_valid=0 captured and DASH_ON_INVALID=1, the digit bytes are '-' and conversion still runs.
- Reset mid-message: on the next edge tx_valid=0 and state=IDLE. The partial message is abandoned with no o_done.
- Input stability: i_data changes after capture have no effect on the message in progress.

Test Plan:
- Basic report: i_data=0x3700_1905, i_valid=1, one i_send pulse, tx_ready=1 -> bytes "H=55.0% T=25.5C\r\n" (17 bytes, back-to-back). First tx_valid at 5+2+2=9 clocks after i_send. One o_done pulse.
- Backpressure: same data, tx_ready toggling 1,0,0,1 pseudo-randomly -> identical 17-byte sequence; tx_data stable on every stalled cycle; no byte dropped or duplicated.
- Invalid and saturation:
  - i_valid=0 -> "H=--.-% T=--.-C\r\n".
  - i_data=0x7B0C_6400, i_valid=1 -> "H=99.9% T=99.0C\r\n".
- Boundary values: i_data=0x0000_0000 -> "H=00.0% T=00.0C\r\n", first tx_valid 2 clocks after i_send. With EOL_CRLF=0 -> 16 bytes ending 0x0A.
- Ignored request: a second i_send during byte 5 and during the o_done cycle -> exactly one message. i_send on the cycle after o_done starts a new message.
- Reset mid-operation: assert rst while byte index 8 is pending -> tx_valid=0, o_busy=0 next edge, no o_done. A fresh i_send then yields a complete message.
